// File: rtl/odd_series_eval.sv
// odd_series_eval: iterative fixed-point evaluator for odd power series
//   f(x) = sum_k s_k * c_k * x^(2k+1), mode 0 tanh, 1 sin, 2 sinh, 3 atan.
// A single shared WIDTH x WIDTH multiplier produces x^2 and the running odd
// power p; a second small product scales p by the ROM coefficient.
// Optional build macro: SERIES_SAT_EN -- when defined, overflowing acc, p and
// xsq values clamp to the signed WIDTH range instead of wrapping.
module odd_series_eval #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int TERMS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    typedef enum logic [2:0] {IDLE, SQ, MAC, PWR, DONE} state_t;

    localparam int KW = 3;
    localparam int PW = 2 * WIDTH + 2;
    localparam logic signed [PW-1:0] MAXV = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(WIDTH+3){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [1:0] MODE_SINH = 2'd2;

    state_t          state;
    logic [1:0]      mode_r;
    logic [KW-1:0]   k;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] xsq;
    logic [WIDTH-1:0] acc;

    logic             launch;
    logic [WIDTH:0]   coef;
    logic [WIDTH:0]   mul_f;
    logic [WIDTH:0]   term_f;
    logic [WIDTH:0]   acc_f;
    logic             sub;
    logic signed [PW-1:0] acc_sum;

    // Rounded coefficient magnitude |coef_k| * 2^FRAC, computed from the exact fractions
    function automatic logic [WIDTH:0] coef_rom(input int m, input int kk);
        longint num;
        longint den;
        num = 0;
        den = 1;
        case (m)
            0: case (kk)
                   0: begin num = 1;    den = 1;      end
                   1: begin num = 1;    den = 3;      end
                   2: begin num = 2;    den = 15;     end
                   3: begin num = 17;   den = 315;    end
                   4: begin num = 62;   den = 2835;   end
                   5: begin num = 1382; den = 155925; end
                   default: begin num = 0; den = 1; end
               endcase
            1, 2: case (kk)
                   0: begin num = 1; den = 1;        end
                   1: begin num = 1; den = 6;        end
                   2: begin num = 1; den = 120;      end
                   3: begin num = 1; den = 5040;     end
                   4: begin num = 1; den = 362880;   end
                   5: begin num = 1; den = 39916800; end
                   default: begin num = 0; den = 1; end
               endcase
            default: begin
                num = (kk < 6) ? 1 : 0;
                den = 2 * kk + 1;
            end
        endcase
        return (WIDTH+1)'((num * (longint'(1) <<< FRAC) * 2 + den) / (2 * den));
    endfunction

    // Sign-extend a WIDTH value to the internal product width
    function automatic logic signed [PW-1:0] sx(input logic [WIDTH-1:0] v);
        return {{(WIDTH+2){v[WIDTH-1]}}, v};
    endfunction

    // Reduce a wide value to WIDTH bits, returning {overflow, value}
    function automatic logic [WIDTH:0] fit(input logic signed [PW-1:0] v);
        logic [WIDTH:0] r;
        if (v > MAXV) begin
`ifdef SERIES_SAT_EN
            r = {1'b1, MAXV[WIDTH-1:0]};
`else
            r = {1'b1, v[WIDTH-1:0]};
`endif
        end else if (v < MINV) begin
`ifdef SERIES_SAT_EN
            r = {1'b1, MINV[WIDTH-1:0]};
`else
            r = {1'b1, v[WIDTH-1:0]};
`endif
        end else begin
            r = {1'b0, v[WIDTH-1:0]};
        end
        return r;
    endfunction

    // Fixed-point multiply: full product, floor shift by FRAC, range reduction
    function automatic logic [WIDTH:0] mulq(input logic signed [PW-1:0] a,
                                            input logic signed [PW-1:0] b);
        logic signed [PW-1:0] prod;
        prod = a * b;
        return fit(prod >>> FRAC);
    endfunction

    // Coefficient lookup for the latched mode and current term index
    always_comb begin
        coef = '0;
        for (int m = 0; m < 4; m++) begin
            for (int kk = 0; kk < 6; kk++) begin
                if (mode_r == 2'(m) && k == KW'(kk)) begin
                    coef = coef_rom(m, kk);
                end
            end
        end
    end

    // Shared multiplier squares x in SQ and advances the odd power in PWR; MAC adds the scaled term
    always_comb begin
        launch  = start && (state == IDLE || state == DONE);
        mul_f   = mulq(sx(p), (state == SQ) ? sx(p) : sx(xsq));
        term_f  = mulq({{(WIDTH+1){1'b0}}, coef}, sx(p));
        sub     = (mode_r != MODE_SINH) && k[0];
        acc_sum = sub ? (sx(acc) - sx(term_f[WIDTH-1:0]))
                      : (sx(acc) + sx(term_f[WIDTH-1:0]));
        acc_f   = fit(acc_sum);
    end

    // Sequencer: IDLE -> SQ -> (MAC -> PWR)* -> MAC -> DONE, start accepted again leaving DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= '0;
            k      <= '0;
            p      <= '0;
            xsq    <= '0;
            acc    <= '0;
            ready  <= 1'b1;
            done   <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (launch) begin
            mode_r <= mode;
            p      <= x;
            acc    <= '0;
            k      <= '0;
            ovf    <= 1'b0;
            ready  <= 1'b0;
            done   <= 1'b0;
            state  <= SQ;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
                SQ: begin
                    xsq   <= mul_f[WIDTH-1:0];
                    ovf   <= ovf | mul_f[WIDTH];
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc_f[WIDTH-1:0];
                    ovf <= ovf | acc_f[WIDTH] | term_f[WIDTH];
                    if (k == KW'(TERMS - 1)) begin
                        result <= acc_f[WIDTH-1:0];
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state <= PWR;
                    end
                end
                PWR: begin
                    p     <= mul_f[WIDTH-1:0];
                    ovf   <= ovf | mul_f[WIDTH];
                    k     <= k + KW'(1);
                    state <= MAC;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odd_series_eval.sv
// tb_odd_series_eval: scoreboard bench for odd_series_eval (WIDTH=16, FRAC=12, TERMS=4).
// Expected results come from a plain-integer series model; a monitor pops them on done.
module tb_odd_series_eval;

    localparam int WIDTH = 16;
    localparam int FRAC  = 12;
    localparam int TERMS = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] x;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;

    int     checks   = 0;
    int     failures = 0;
    longint cycleCnt = 0;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        longint      edgeNo;
    } exp_t;

    exp_t expQ[$];

    odd_series_eval #(.WIDTH(WIDTH), .FRAC(FRAC), .TERMS(TERMS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .x      (x),
        .ready  (ready),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Bring a value into the signed 16-bit range, flagging overflow
    function automatic longint fitModel(input longint v, inout bit of);
        longint w;
        if (v > 32767 || v < -32768) begin
            of = 1'b1;
`ifdef SERIES_SAT_EN
            w = (v > 32767) ? 32767 : -32768;
`else
            w = v & 65535;
            if (w >= 32768) w = w - 65536;
`endif
        end else begin
            w = v;
        end
        return w;
    endfunction

    // Series f(x) = sum s_k c_k x^(2k+1) in Q4.12 integers with floor scaling
    function automatic void model(input int m, input logic [15:0] xv,
                                  output logic [15:0] r, output logic o);
        longint cf [0:3][0:5];
        longint xs, pw, acc, t;
        bit     of;
        cf = '{'{4096, 1365, 546, 221, 90, 36},
               '{4096, 683, 34, 1, 0, 0},
               '{4096, 683, 34, 1, 0, 0},
               '{4096, 1365, 819, 585, 455, 372}};
        of  = 1'b0;
        pw  = longint'($signed(xv));
        xs  = fitModel((pw * pw) >>> FRAC, of);
        acc = 0;
        for (int kk = 0; kk < TERMS; kk++) begin
            if (kk > 0) pw = fitModel((pw * xs) >>> FRAC, of);
            t = (cf[m][kk] * pw) >>> FRAC;
            if (m != 2 && (kk % 2) == 1) acc = fitModel(acc - t, of);
            else                         acc = fitModel(acc + t, of);
        end
        r = acc[15:0];
        o = of;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    function automatic void pushExpected(input int m, input logic [15:0] xv, input longint edgeNo);
        exp_t e;
        model(m, xv, e.res, e.ovf);
        e.edgeNo = edgeNo;
        expQ.push_back(e);
    endfunction

    // Issue one start pulse once the unit is ready; scrambles mode/x afterwards
    task automatic applyStimulus(input int m, input logic [15:0] xv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("ready_timeout", 0, 1);
        start = 1'b1;
        mode  = 2'(m);
        x     = xv;
        @(posedge clk);
        #1;
        pushExpected(m, xv, cycleCnt);
        start = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        x     = 16'($urandom);
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || ready !== 1'b1) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("drain_timeout", longint'(expQ.size()), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("result", longint'(result), longint'(e.res));
                checkOutput("ovf", longint'(ovf), longint'(e.ovf));
                checkOutput("latency", cycleCnt - e.edgeNo, 2 * TERMS);
            end
        end
    end

    initial begin
        int     lowCnt;
        int     guard;
        longint e0;
        logic [15:0] hx;

        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        x     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", longint'(ready), 1);
        checkOutput("reset_done", longint'(done), 0);
        checkOutput("reset_result", longint'(result), 0);
        checkOutput("reset_ovf", longint'(ovf), 0);
        rst = 1'b0;

        // tanh 0.5, also measure how long ready stays low
        applyStimulus(0, 16'h0800);
        lowCnt = 0;
        guard  = 0;
        while (guard < 50) begin
            @(negedge clk);
            guard++;
            if (ready === 1'b0) lowCnt++;
            else break;
        end
        checkOutput("ready_low_cycles", lowCnt, 2 * TERMS + 1);
        waitDrain();

        applyStimulus(1, 16'h0800);
        applyStimulus(0, 16'hF800);
        applyStimulus(2, 16'h7FFF);
        applyStimulus(3, 16'h0000);
        applyStimulus(1, 16'h8000);
        applyStimulus(3, 16'h8000);
        applyStimulus(0, 16'h7FFF);
        waitDrain();

        // Second start pulse during a run must be ignored
        applyStimulus(0, 16'h0C00);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 2'd1;
        x     = 16'h0400;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain();
        repeat (20) @(negedge clk);
        checkOutput("idle_after_ignored_start", longint'(ready), 1);

        // Start held high: back-to-back runs every 2*TERMS+1 cycles
        hx = 16'($urandom_range(0, 16'h1800));
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd2;
        x     = hx;
        @(posedge clk);
        #1;
        e0 = cycleCnt;
        for (int i = 0; i < 3; i++) pushExpected(2, hx, e0 + i * (2 * TERMS + 1));
        repeat (2 * (2 * TERMS + 1)) @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain();

        // Reset in the middle of a run aborts it
        applyStimulus(0, 16'h0800);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", longint'(ready), 1);
        checkOutput("abort_result", longint'(result), 0);
        checkOutput("abort_ovf", longint'(ovf), 0);
        checkOutput("abort_done", longint'(done), 0);
        expQ.delete();
        rst = 1'b0;
        repeat (15) @(negedge clk);
        applyStimulus(1, 16'h0800);
        waitDrain();

        // Randomized operands over all modes
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) applyStimulus(int'($urandom_range(0, 3)), 16'($urandom));
            else            applyStimulus(int'($urandom_range(0, 3)),
                                          16'($signed(16'($urandom_range(0, 16'h3000))) - 16'sh1800));
        end
        waitDrain();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
